nco_frame_analyzer: RTL and testbench
=====================================

Name: nco_frame_analyzer

Overview:
- Downstream consumer of the NCO output. Takes the NCO's signal_out select and its wave_out samples.
- Splits the sample stream into fixed-length frames, each tagged with the active select.
- Per frame, computes min, max and sum, and queues the result in a small FIFO for a ready/valid consumer such as a scoreboard tap or a register readout.
- Signals frames lost to a select change or a full FIFO.

Parameters:
- SELECT_WIDTH, 3, width of signal_out (matches `SELECT_WIDTH).
- WAVE_WIDTH, 8, unsigned sample width (matches `WAVE_WIDTH).
- FRAME_LEN, 32, samples per frame; power of two, minimum 2.
- SETTLE, 1, samples discarded after enable or a select change; 0 is legal.
- FIFO_DEPTH, 4, result entries; power of two.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  analysis enable.
- signal_out  in  SELECT_WIDTH  NCO waveform select.
- wave_out  in  WAVE_WIDTH  NCO sample, one per cycle.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head.
- res_sel  out  SELECT_WIDTH  select of head frame.
- res_min  out  WAVE_WIDTH  minimum sample of head frame.
- res_max  out  WAVE_WIDTH  maximum sample of head frame.
- res_sum  out  WAVE_WIDTH+log2(FRAME_LEN)  sum of head frame; exact, never wraps.
- frame_abort  out  1  one-cycle pulse: partial frame discarded.
- overflow  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, sample count=0, FIFO empty.
  - All outputs 0.
  - sel_q<=signal_out, so leaving reset never counts as a select change.
  - Reset mid-frame discards all data; outputs are 0 the cycle after reset is sampled.
- Change detect: chg = (signal_out != sel_q). sel_q is updated every cycle.
- Timing basis: wave_out lags signal_out by one cycle. The sample in a chg cycle therefore still belongs to the old select.
- States:
  - IDLE: no sampling. enable=1 -> SETTLE, or COLLECT if SETTLE==0.
  - SETTLE: discard samples. Count SETTLE cycles, then -> COLLECT. chg restarts the count.
  - COLLECT: accumulate wave_out into min, max and sum. Frame select = sel_q captured at frame start.
- enable=0 in any state -> IDLE next cycle. A partial frame is discarded and frame_abort pulses.
- chg in COLLECT, with the sample count below FRAME_LEN-1:
  - Discard the partial frame, including the sample in the chg cycle.
  - Pulse frame_abort the next cycle.
  - -> SETTLE (or a fresh COLLECT if SETTLE==0).
- chg in COLLECT on sample FRAME_LEN-1:
  - The sample completes the old frame, tagged with the old select; the result is pushed.
  - Then SETTLE for the new select. No abort.
- Frame complete without chg:
  - Push the result.
  - Restart COLLECT immediately with accumulators cleared. Back-to-back frames have no gap.
- Accumulator init per frame: min=all ones, max=0, sum=0. The first sample therefore sets min and max.
- Push timing: the result is written at the clock edge ending the last sample cycle. res_valid rises the next cycle if the FIFO was empty.
- FIFO is first-word-fall-through: res_* show the head whenever res_valid=1. res_* hold stable while res_valid=1 and res_ready=0.
- Pop occurs when res_valid & res_ready.
- Full FIFO:
  - A push without a simultaneous pop drops the result and sets overflow.
  - Push and pop in the same cycle while full: both are accepted.
- overflow clears only on reset.
- Empty FIFO: res_valid=0 and res_* = 0.
- Simultaneous push and pop while empty: the push is stored. res_valid rises the next cycle; no bypass.

Test Plan:
- Reset, enable=1, signal_out=2 constant, wave_out ramp 0..32 from the first post-reset cycle (SETTLE=1 discards 0) -> exactly one result: sel=2, min=1, max=32, sum=528. res_valid rises the cycle after sample 32.
- wave_out=255 constant, select 5, two back-to-back frames -> two results, each min=max=255, sum=8160. Pushes 32 cycles apart.
- Select 1->3 at sample index 10 of a frame -> frame_abort high for 1 cycle, no result pushed. Next result has sel=3 and appears after 1 settle cycle plus 32 samples.
- Select 1->3 exactly at sample index 31 -> one result with sel=1 covering all 32 samples, no abort. Next result has sel=3.
- res_ready=0 while 5 frames complete -> 4 entries held, overflow=1, fifth frame lost. Then res_ready=1 drains in frame order. A pop and push in the same cycle while full loses nothing.
- reset pulsed mid-frame while the FIFO holds 2 entries -> next cycle res_valid=0, overflow=0, all outputs 0. A fresh frame completes 33 cycles after reset deasserts.

Source files
------------

// File: rtl/nco_frame_analyzer.sv
// rtl/nco_frame_analyzer.sv - splits NCO samples into select-tagged frames and queues min/max/sum results

module nco_frame_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         s_tvalid,
   input  logic [W-1:0] s_tdata,
   output logic         s_tready,
   output logic         m_tvalid,
   output logic [W-1:0] m_tdata,
   input  logic         m_tready
);
   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic         empty, full, rd_en, wr_en;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign m_tvalid = !empty;
   assign rd_en    = m_tvalid & m_tready;
   // A full queue still accepts a write when the head leaves in the same cycle.
   assign s_tready = !full | rd_en;
   assign wr_en    = s_tvalid & s_tready;
   assign m_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = s_tdata;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

module nco_frame_analyzer #(
   parameter int SELECT_WIDTH = 3,
   parameter int WAVE_WIDTH   = 8,
   parameter int FRAME_LEN    = 32,
   parameter int SETTLE       = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    enable,
   input  logic [SELECT_WIDTH-1:0]                 signal_out,
   input  logic [WAVE_WIDTH-1:0]                   wave_out,
   output logic                                    res_valid,
   input  logic                                    res_ready,
   output logic [SELECT_WIDTH-1:0]                 res_sel,
   output logic [WAVE_WIDTH-1:0]                   res_min,
   output logic [WAVE_WIDTH-1:0]                   res_max,
   output logic [WAVE_WIDTH+$clog2(FRAME_LEN)-1:0] res_sum,
   output logic                                    frame_abort,
   output logic                                    overflow
);
   localparam int CW  = $clog2(FRAME_LEN);
   localparam int SW  = WAVE_WIDTH + CW;
   localparam int SCW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam int RW  = SELECT_WIDTH + 2 * WAVE_WIDTH + SW;
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COLLECT} state_t;
   localparam state_t AFTER_CHG = (SETTLE == 0) ? ST_COLLECT : ST_SETTLE;

   state_t                  state_q, state_d;
   logic [SELECT_WIDTH-1:0] sel_q, sel_d, fsel_q, fsel_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SCW-1:0]          scnt_q, scnt_d;
   logic [WAVE_WIDTH-1:0]   min_q, min_d, max_q, max_d, nmin, nmax;
   logic [SW-1:0]           sum_q, sum_d, nsum;
   logic                    abort_q, abort_d, ovf_q, ovf_d;
   logic                    chg, push, clr, fifo_ready;
   logic [RW-1:0]           head;

   assign chg  = (signal_out != sel_q);
   assign nmin = (wave_out < min_q) ? wave_out : min_q;
   assign nmax = (wave_out > max_q) ? wave_out : max_q;
   assign nsum = sum_q + SW'(wave_out);

   always_comb begin
      state_d = state_q;
      sel_d   = signal_out;
      fsel_d  = fsel_q;
      cnt_d   = cnt_q;
      scnt_d  = scnt_q;
      min_d   = min_q;
      max_d   = max_q;
      sum_d   = sum_q;
      abort_d = 1'b0;
      push    = 1'b0;
      clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The cycle that sees enable is itself the first discarded sample.
            if (enable) begin
               if (SETTLE == 0 || (SETTLE == 1 && !chg)) begin
                  state_d = ST_COLLECT;
               end else begin
                  state_d = ST_SETTLE;
                  scnt_d  = chg ? '0 : SCW'(1);
               end
            end
         end
         ST_SETTLE: begin
            if (chg) begin
               scnt_d = '0;
            end else if (int'(scnt_q) + 1 >= SETTLE) begin
               state_d = ST_COLLECT;
               scnt_d  = '0;
            end else begin
               scnt_d = scnt_q + SCW'(1);
            end
         end
         ST_COLLECT: begin
            if (cnt_q == '0) fsel_d = sel_q;
            if (chg && cnt_q != LAST) begin
               abort_d = 1'b1;
               clr     = 1'b1;
               state_d = AFTER_CHG;
               scnt_d  = '0;
            end else if (cnt_q == LAST) begin
               push = 1'b1;
               clr  = 1'b1;
               if (chg) begin
                  state_d = AFTER_CHG;
                  scnt_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               min_d = nmin;
               max_d = nmax;
               sum_d = nsum;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!enable) begin
         abort_d = (state_q == ST_COLLECT) && (cnt_q != '0);
         state_d = ST_IDLE;
         push    = 1'b0;
         clr     = 1'b1;
      end
      if (clr) begin
         cnt_d = '0;
         min_d = '1;
         max_d = '0;
         sum_d = '0;
      end
      ovf_d = ovf_q | (push & !fifo_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= signal_out;
         fsel_q  <= '0;
         cnt_q   <= '0;
         scnt_q  <= '0;
         min_q   <= '1;
         max_q   <= '0;
         sum_q   <= '0;
         abort_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         fsel_q  <= fsel_d;
         cnt_q   <= cnt_d;
         scnt_q  <= scnt_d;
         min_q   <= min_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         abort_q <= abort_d;
         ovf_q   <= ovf_d;
      end
   end

   nco_frame_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .s_tvalid (push),
      .s_tdata  ({fsel_q, nmin, nmax, nsum}),
      .s_tready (fifo_ready),
      .m_tvalid (res_valid),
      .m_tdata  (head),
      .m_tready (res_ready)
   );

   assign {res_sel, res_min, res_max, res_sum} = head;
   assign frame_abort = abort_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_nco_frame_analyzer.sv
// tb/tb_nco_frame_analyzer.sv - directed frame vectors and corner sequences for nco_frame_analyzer

module tb_nco_frame_analyzer;
   logic        clk = 1'b0;
   logic        reset, enable, res_ready, res_valid, frame_abort, overflow;
   logic [2:0]  signal_out, res_sel;
   logic [7:0]  wave_out, res_min, res_max;
   logic [12:0] res_sum;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int start;
      int step;
      int emin;
      int emax;
      int esum;
   } frame_t;
   frame_t ft [6];

   always #5 clk = ~clk;

   nco_frame_analyzer dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .signal_out  (signal_out),
      .wave_out    (wave_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_sel     (res_sel),
      .res_min     (res_min),
      .res_max     (res_max),
      .res_sum     (res_sum),
      .frame_abort (frame_abort),
      .overflow    (overflow)
   );

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string nm, input int s, input int mn, input int mx, input int sm);
      chk({nm, " valid"}, int'(res_valid), 1);
      chk({nm, " sel"}, int'(res_sel), s);
      chk({nm, " min"}, int'(res_min), mn);
      chk({nm, " max"}, int'(res_max), mx);
      chk({nm, " sum"}, int'(res_sum), sm);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " valid"}, int'(res_valid), 0);
      chk({nm, " sel"}, int'(res_sel), 0);
      chk({nm, " min"}, int'(res_min), 0);
      chk({nm, " max"}, int'(res_max), 0);
      chk({nm, " sum"}, int'(res_sum), 0);
      chk({nm, " abort"}, int'(frame_abort), 0);
      chk({nm, " overflow"}, int'(overflow), 0);
   endtask

   task automatic drv(input logic en, input int s, input int w, input logic r);
      enable     = en;
      signal_out = 3'(s);
      wave_out   = 8'(w);
      res_ready  = r;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the start of the first post-reset cycle.
   task automatic do_reset(input int s);
      reset = 1'b1;
      drv(1'b1, s, 0, 1'b0);
      adv();
      reset = 1'b0;
   endtask

   initial begin
      int bad;
      int w;
      int j;
      int i;
      int k;
      ft[0] = '{255,  0, 255, 255, 8160};
      ft[1] = '{255,  0, 255, 255, 8160};
      ft[2] = '{ 10,  3,  10, 103, 1808};
      ft[3] = '{200, -5,  45, 200, 3920};
      ft[4] = '{  0,  0,   0,   0,    0};
      ft[5] = '{224,  1, 224, 255, 7664};

      // Ramp 0..32 on select 2: sample 0 is discarded, 1..32 form the frame.
      do_reset(2);
      drv(1'b1, 2, 0, 1'b0);
      chk_zero("reset");
      adv();
      for (int c = 1; c <= 33; c++) begin
         drv(1'b1, 2, c, c == 33);
         if (c == 32) chk("A valid before push", int'(res_valid), 0);
         if (c == 33) chk_res("A ramp", 2, 1, 32, 528);
         adv();
      end

      // Back-to-back frames from the vector table on select 5.
      do_reset(5);
      drv(1'b1, 5, 0, 1'b1);
      adv();
      bad = 0;
      for (int c = 1; c <= 193; c++) begin
         j = (c - 1) / 32;
         i = (c - 1) % 32;
         w = (j < 6) ? ft[j].start + ft[j].step * i : 0;
         drv(1'b1, 5, w, 1'b1);
         if (c >= 33 && i == 0) begin
            k = (c - 33) / 32;
            chk_res($sformatf("B frame%0d", k), 5, ft[k].emin, ft[k].emax, ft[k].esum);
         end else if (res_valid || frame_abort) begin
            bad++;
         end
         adv();
      end
      chk("B spurious valid/abort", bad, 0);
      chk("B overflow", int'(overflow), 0);

      // Select 1->3 at sample index 10 aborts the partial frame.
      do_reset(1);
      bad = 0;
      for (int c = 0; c <= 45; c++) begin
         drv(1'b1, (c >= 11) ? 3 : 1, c, 1'b1);
         if (c == 12) chk("C abort pulse", int'(frame_abort), 1);
         if (c == 13) chk("C abort end", int'(frame_abort), 0);
         if (c < 45 && res_valid) bad++;
         if (c == 45) chk_res("C after abort", 3, 13, 44, 912);
         adv();
      end
      chk("C no early result", bad, 0);

      // Select 1->3 on the last sample completes the old frame.
      do_reset(1);
      bad = 0;
      for (int c = 0; c <= 66; c++) begin
         drv(1'b1, (c >= 32) ? 3 : 1, c, 1'b1);
         if (frame_abort) bad++;
         if (c == 33) chk_res("D old sel", 1, 1, 32, 528);
         else if (c == 66) chk_res("D new sel", 3, 34, 65, 1584);
         else if (res_valid) bad++;
         adv();
      end
      chk("D no abort/stray", bad, 0);

      // Five frames with the consumer stalled, then a full pop+push and drain.
      do_reset(4);
      for (int c = 0; c <= 197; c++) begin
         w = (c == 0) ? 0 : (c - 1) / 32 + 1;
         drv(1'b1, 4, w, c >= 192);
         if (c == 100) chk_res("E hold", 4, 1, 1, 32);
         if (c == 160) chk("E overflow before", int'(overflow), 0);
         if (c == 161) chk("E overflow set", int'(overflow), 1);
         if (c == 192) chk_res("E full head", 4, 1, 1, 32);
         if (c == 193) chk_res("E drain1", 4, 2, 2, 64);
         if (c == 194) chk_res("E drain2", 4, 3, 3, 96);
         if (c == 195) chk_res("E drain3", 4, 4, 4, 128);
         if (c == 196) chk_res("E drain5", 4, 6, 6, 192);
         if (c == 197) begin
            chk("E empty", int'(res_valid), 0);
            chk("E overflow sticky", int'(overflow), 1);
         end
         adv();
      end

      // Reset mid-frame with two results queued.
      do_reset(6);
      for (int c = 0; c <= 104; c++) begin
         reset = (c == 70);
         drv(1'b1, 6, c, c >= 104);
         if (c == 0) chk("F overflow cleared", int'(overflow), 0);
         if (c == 69) chk_res("F queued head", 6, 1, 32, 528);
         if (c == 71) chk_zero("F after reset");
         if (c == 103) chk("F valid before", int'(res_valid), 0);
         if (c == 104) chk_res("F fresh frame", 6, 72, 103, 2800);
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
